// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner of the 3-digit 7-segment scanner.
// Grants one value source at a time, holds it for HOLD_TICKS, latches its
// binary value and converts it to BCD with a one-bit-per-tick double-dabble.
module display_arbiter #(
  parameter int unsigned N_REQ      = 3,
  parameter int unsigned VAL_W      = 10,
  parameter int unsigned HOLD_TICKS = 140
) (
  input  logic                   clk_70hz,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*VAL_W-1:0] value,
  output logic [3:0]             ones,
  output logic [3:0]             tens,
  output logic [3:0]             hundreds,
  output logic                   enable,
  output logic [N_REQ-1:0]       grant,
  output logic                   overflow
);

  localparam int unsigned IdxW  = $clog2(N_REQ);
  localparam int unsigned StepW = $clog2(VAL_W + 1);
  localparam int unsigned HoldW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {StIdle, StConvert, StShow} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [VAL_W-1:0]     opnd_q, opnd_d;
  logic [11:0]          bcd_q, bcd_d;
  logic [StepW-1:0]     step_q, step_d;
  logic [HoldW-1:0]     hold_q, hold_d;
  logic [11:0]          digits_q, digits_d;
  logic                 enable_q, enable_d;
  logic                 overflow_q, overflow_d;

  logic                 win_found;
  logic [IdxW-1:0]      win_idx;
  logic [IdxW-1:0]      cand;
  logic [VAL_W-1:0]     slice;
  logic                 slice_ovf;
  logic [VAL_W-1:0]     operand_new;
  logic [11:0]          bcd_adj;
  logic [11:0]          bcd_step;
  logic                 do_arb;

  // Round-robin search starting one past the last owner; the last owner is
  // checked last, so it only wins again when nobody else is requesting.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Select the winner's value and clamp it to the displayable range.
  always_comb begin
    slice = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == IdxW'(i)) slice = value[i*VAL_W +: VAL_W];
    end
    slice_ovf   = (32'(slice) > 32'd999);
    operand_new = slice_ovf ? VAL_W'(999) : slice;
  end

  // One double-dabble step: correct nibbles >= 5, then shift in operand MSB.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned n = 0; n < 3; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[10:0], opnd_q[VAL_W-1]};
  end

  // Next-state logic for the IDLE/CONVERT/SHOW controller and datapath.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    opnd_d     = opnd_q;
    bcd_d      = bcd_q;
    step_d     = step_q;
    hold_d     = hold_q;
    digits_d   = digits_q;
    enable_d   = enable_q;
    overflow_d = overflow_q;
    do_arb     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req) do_arb = 1'b1;
      end
      StConvert: begin
        bcd_d  = bcd_step;
        opnd_d = opnd_q << 1;
        step_d = step_q + StepW'(1);
        // Digits only update with a finished conversion; old ones stay frozen.
        if (step_q == StepW'(VAL_W - 1)) begin
          digits_d = bcd_step;
          enable_d = 1'b1;
          hold_d   = '0;
          state_d  = StShow;
        end
      end
      StShow: begin
        hold_d = hold_q + HoldW'(1);
        if ((hold_q == HoldW'(HOLD_TICKS - 1)) || !(|(req & grant_q))) begin
          if (|req) begin
            do_arb = 1'b1;
          end else begin
            state_d    = StIdle;
            enable_d   = 1'b0;
            digits_d   = '0;
            grant_d    = '0;
            overflow_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Arbitration also restarts the converter; enable is left as-is so a
    // SHOW->CONVERT hand-over never blanks the display.
    if (do_arb) begin
      state_d    = StConvert;
      grant_d    = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
      rr_ptr_d   = win_idx;
      overflow_d = slice_ovf;
      opnd_d     = operand_new;
      bcd_d      = '0;
      step_d     = '0;
    end
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk_70hz or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= IdxW'(N_REQ - 1);
      grant_q    <= '0;
      opnd_q     <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      hold_q     <= '0;
      digits_q   <= '0;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      opnd_q     <= opnd_d;
      bcd_q      <= bcd_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      digits_q   <= digits_d;
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
    end
  end

  assign ones     = digits_q[3:0];
  assign tens     = digits_q[7:4];
  assign hundreds = digits_q[11:8];
  assign enable   = enable_q;
  assign grant    = grant_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter (N_REQ=3, VAL_W=10, HOLD_TICKS=4).
module tb_display_arbiter;

  logic        clk_70hz;
  logic        reset;
  logic [2:0]  req;
  logic [29:0] value;
  logic [3:0]  ones, tens, hundreds;
  logic        enable;
  logic [2:0]  grant;
  logic        overflow;

  int tests_run;
  int tests_failed;

  display_arbiter #(
    .N_REQ     (3),
    .VAL_W     (10),
    .HOLD_TICKS(4)
  ) dut (
    .clk_70hz(clk_70hz),
    .reset   (reset),
    .req     (req),
    .value   (value),
    .ones    (ones),
    .tens    (tens),
    .hundreds(hundreds),
    .enable  (enable),
    .grant   (grant),
    .overflow(overflow)
  );

  initial clk_70hz = 1'b0;
  always #5 clk_70hz = ~clk_70hz;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_70hz);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = 3'b000;
    value = '0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 3'b111;
    value = {10'd100, 10'd200, 10'd300};
    tick(2);
    tests_run++;
    if ({enable, grant, overflow, hundreds, tens, ones} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got en=%b g=%b ov=%b d=%h%h%h want all zero",
               enable, grant, overflow, hundreds, tens, ones);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    req   = 3'b001;
    value = {10'd0, 10'd0, 10'd472};
    tick(1);
    tests_run++;
    if (grant !== 3'b001 || enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_grant: got g=%b en=%b want g=001 en=0", grant, enable);
    end
    tick(9);
    tests_run++;
    if (enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_early_enable: got en=%b want 0", enable);
    end
    tick(1);
    tests_run++;
    if (enable !== 1'b1 || {hundreds, tens, ones} !== 12'h472) begin
      tests_failed++;
      $display("FAIL single_digits: got en=%b d=%h%h%h want en=1 d=472",
               enable, hundreds, tens, ones);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_g [4];
    logic [11:0] exp_d [3];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    exp_d[0] = 12'h005; exp_d[1] = 12'h060; exp_d[2] = 12'h700;
    apply_reset();
    req   = 3'b111;
    value = {10'd700, 10'd60, 10'd5};
    tick(1);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (grant !== exp_g[i]) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: got %b want %b", i, grant, exp_g[i]);
      end
      tick(10);
      tests_run++;
      if (enable !== 1'b1 || {hundreds, tens, ones} !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL rr_digits%0d: got en=%b d=%h%h%h want en=1 d=%h",
                 i, enable, hundreds, tens, ones, exp_d[i]);
      end
      tick(3);
      tests_run++;
      if (grant !== exp_g[i]) begin
        tests_failed++;
        $display("FAIL rr_hold%0d: got %b want %b", i, grant, exp_g[i]);
      end
      tick(1);
      tests_run++;
      if (grant !== exp_g[i+1] || enable !== 1'b1 || {hundreds, tens, ones} !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL rr_handover%0d: got g=%b en=%b d=%h%h%h want g=%b en=1 d=%h",
                 i, grant, enable, hundreds, tens, ones, exp_g[i+1], exp_d[i]);
      end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    req   = 3'b010;
    value = {10'd0, 10'd1023, 10'd0};
    tick(1);
    tests_run++;
    if (grant !== 3'b010 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_latch: got g=%b ov=%b want g=010 ov=1", grant, overflow);
    end
    tick(10);
    tests_run++;
    if ({hundreds, tens, ones} !== 12'h999) begin
      tests_failed++;
      $display("FAIL ovf_clamp: got %h%h%h want 999", hundreds, tens, ones);
    end
    value = {10'd0, 10'd123, 10'd0};
    tick(4);
    tests_run++;
    if (grant !== 3'b010 || overflow !== 1'b0 || {hundreds, tens, ones} !== 12'h999) begin
      tests_failed++;
      $display("FAIL ovf_regrant: got g=%b ov=%b d=%h%h%h want g=010 ov=0 d=999",
               grant, overflow, hundreds, tens, ones);
    end
    tick(10);
    tests_run++;
    if ({hundreds, tens, ones} !== 12'h123 || enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_refresh: got en=%b d=%h%h%h want en=1 d=123",
               enable, hundreds, tens, ones);
    end
  endtask

  task automatic test_release();
    apply_reset();
    req   = 3'b001;
    value = {10'd0, 10'd0, 10'd250};
    tick(11);
    tests_run++;
    if ({hundreds, tens, ones} !== 12'h250 || enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL rel_show: got en=%b d=%h%h%h want en=1 d=250",
               enable, hundreds, tens, ones);
    end
    req = 3'b000;
    tick(1);
    tests_run++;
    if ({enable, grant, overflow, hundreds, tens, ones} !== 17'd0) begin
      tests_failed++;
      $display("FAIL rel_idle: got en=%b g=%b ov=%b d=%h%h%h want all zero",
               enable, grant, overflow, hundreds, tens, ones);
    end
  endtask

  task automatic test_value_frozen();
    apply_reset();
    req   = 3'b001;
    value = {10'd0, 10'd0, 10'd999};
    tick(11);
    value = '0;
    tests_run++;
    if ({hundreds, tens, ones} !== 12'h999) begin
      tests_failed++;
      $display("FAIL frz_show: got %h%h%h want 999", hundreds, tens, ones);
    end
    tick(3);
    tests_run++;
    if ({hundreds, tens, ones} !== 12'h999 || enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL frz_hold: got en=%b d=%h%h%h want en=1 d=999",
               enable, hundreds, tens, ones);
    end
    tick(1);
    tests_run++;
    if ({hundreds, tens, ones} !== 12'h999 || enable !== 1'b1 || grant !== 3'b001) begin
      tests_failed++;
      $display("FAIL frz_reconv: got en=%b g=%b d=%h%h%h want en=1 g=001 d=999",
               enable, grant, hundreds, tens, ones);
    end
    tick(10);
    tests_run++;
    if ({hundreds, tens, ones} !== 12'h000 || enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL frz_new: got en=%b d=%h%h%h want en=1 d=000",
               enable, hundreds, tens, ones);
    end
  endtask

  task automatic test_reset_mid_convert();
    apply_reset();
    req   = 3'b001;
    value = {10'd0, 10'd0, 10'd472};
    tick(6);
    tests_run++;
    if (grant !== 3'b001 || enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_pre: got g=%b en=%b want g=001 en=0", grant, enable);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({enable, grant, overflow, hundreds, tens, ones} !== 17'd0) begin
      tests_failed++;
      $display("FAIL midrst_async: got en=%b g=%b ov=%b d=%h%h%h want all zero",
               enable, grant, overflow, hundreds, tens, ones);
    end
    tick(1);
    reset = 1'b0;
    req   = 3'b011;
    value = {10'd0, 10'd31, 10'd472};
    tick(1);
    tests_run++;
    if (grant !== 3'b001) begin
      tests_failed++;
      $display("FAIL midrst_first: got %b want 001", grant);
    end
    tick(10);
    tests_run++;
    if ({hundreds, tens, ones} !== 12'h472 || enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_digits: got en=%b d=%h%h%h want en=1 d=472",
               enable, hundreds, tens, ones);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    req          = 3'b000;
    value        = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_release();
    test_value_frozen();
    test_reset_mid_convert();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
